port_bus_arbiter: RTL

Two-master arbiter for the 8-bit housekeeping port bus (port_id / out_port / write_strobe / read_strobe / in_port). It lets the soft CPU (master 0) and a second agent, such as a host/debug bridge (master 1), share the same register-port address space. Each master gets whole, non-overlapping transactions, with round-robin fairness. It sits between the masters and the existing out-port register bank / in-port mux, and it sequences each access as setup → strobe → capture.

---
 rtl/port_bus_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/port_bus_arbiter.sv
// rtl/port_bus_arbiter.sv - two-master round-robin arbiter for the 8-bit port bus
// Each granted access runs setup -> strobe -> capture/ack as whole, non-overlapping transactions.
module port_bus_arbiter #(
  parameter int unsigned SETUP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [7:0] m0_port_id,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [7:0] m1_port_id,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  output logic       busy,
  output logic       grant
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       last_q;
  logic       grant_q;
  logic       we_q;
  logic [7:0] port_id_q;
  logic [7:0] out_port_q;
  logic [7:0] m0_rdata_q;
  logic [7:0] m1_rdata_q;
  logic       write_strobe_q;
  logic       read_strobe_q;
  logic       m0_ack_q;
  logic       m1_ack_q;
  logic       busy_q;
  logic       pick_d;

  // On a tie the master that did not own the previous transaction wins.
  always_comb begin
    pick_d = m1_req;
    if (m0_req && m1_req) begin
      pick_d = ~last_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      last_q         <= 1'b1;
      grant_q        <= 1'b0;
      we_q           <= 1'b0;
      port_id_q      <= 8'd0;
      out_port_q     <= 8'd0;
      m0_rdata_q     <= 8'd0;
      m1_rdata_q     <= 8'd0;
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant_q <= pick_d;
            if (pick_d) begin
              we_q      <= m1_we;
              port_id_q <= m1_port_id;
              if (m1_we) out_port_q <= m1_wdata;
            end else begin
              we_q      <= m0_we;
              port_id_q <= m0_port_id;
              if (m0_we) out_port_q <= m0_wdata;
            end
            cnt_q   <= 4'(SETUP_CYCLES - 1);
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            write_strobe_q <= we_q;
            read_strobe_q  <= ~we_q;
            state_q        <= STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          // in_port is sampled on the same edge that write targets register out_port.
          if (!we_q) begin
            if (grant_q) m1_rdata_q <= in_port;
            else         m0_rdata_q <= in_port;
          end
          write_strobe_q <= 1'b0;
          read_strobe_q  <= 1'b0;
          m0_ack_q       <= ~grant_q;
          m1_ack_q       <= grant_q;
          last_q         <= grant_q;
          state_q        <= DONE;
        end
        DONE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_id      = port_id_q;
  assign out_port     = out_port_q;
  assign write_strobe = write_strobe_q;
  assign read_strobe  = read_strobe_q;
  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign busy         = busy_q;
  assign grant        = grant_q;

endmodule
